// File: rtl/frost32_mem_access_ctrl.sv
// Memory access controller between the Frost32 core and a synchronous 32-bit
// byte-enabled word RAM: lane steering, fault screening and wait-state timing.
module frost32_mem_access_ctrl #(
    parameter int unsigned RAM_WORD_ADDR_WIDTH = 14,
    parameter int unsigned WAIT_STATES         = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_req_mem_access,
    input  logic [31:0]                    in_addr,
    input  logic [31:0]                    in_data,
    input  logic                           in_access_type,
    input  logic [1:0]                     in_access_size,
    output logic [31:0]                    out_data,
    output logic                           out_data_ready,
    output logic                           out_fault,
    output logic                           out_busy,
    output logic [RAM_WORD_ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]                    ram_wdata,
    output logic [3:0]                     ram_byte_en,
    output logic                           ram_we,
    output logic                           ram_re,
    input  logic [31:0]                    ram_rdata
);

    localparam int unsigned CNT_W       = 3;
    localparam int unsigned BYTE_ADDR_W = RAM_WORD_ADDR_WIDTH + 2;

    typedef enum logic [1:0] {StIdle, StAccess, StWait, StRespond} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               acc_write_q, acc_write_d;
    logic [1:0]         acc_size_q, acc_size_d;
    logic [1:0]         acc_lane_q, acc_lane_d;

    logic [31:0]                    out_data_d;
    logic                           out_data_ready_d, out_fault_d, out_busy_d;
    logic [RAM_WORD_ADDR_WIDTH-1:0] ram_addr_d;
    logic [31:0]                    ram_wdata_d;
    logic [3:0]                     ram_byte_en_d;
    logic                           ram_we_d, ram_re_d;

    logic        req_fault_c, accept_c, reject_c;
    logic [3:0]  lanes_c;
    logic [31:0] wdata_c, rd_extract_c;

    // Request screening and lane steering for the incoming request
    always_comb begin
        req_fault_c = 1'b0;
        lanes_c     = 4'b0000;
        wdata_c     = 32'd0;
        case (in_access_size)
            2'd0: begin
                req_fault_c = (in_addr[1:0] != 2'b00);
                lanes_c     = 4'b1111;
                wdata_c     = in_data;
            end
            2'd1: begin
                req_fault_c = in_addr[0];
                lanes_c     = in_addr[1] ? 4'b1100 : 4'b0011;
                wdata_c     = {2{in_data[15:0]}};
            end
            2'd2: begin
                lanes_c = 4'b0001 << in_addr[1:0];
                wdata_c = {4{in_data[7:0]}};
            end
            default: req_fault_c = 1'b1;
        endcase
        if ((in_addr >> BYTE_ADDR_W) != 32'd0) begin
            req_fault_c = 1'b1;
        end
    end

    assign accept_c = (state_q == StIdle) && in_req_mem_access && !req_fault_c;
    assign reject_c = (state_q == StIdle) && in_req_mem_access && req_fault_c;

    // Zero-extended lane extraction of the returned RAM word
    always_comb begin
        case (acc_size_q)
            2'd1:    rd_extract_c = acc_lane_q[1] ? {16'h0, ram_rdata[31:16]}
                                                  : {16'h0, ram_rdata[15:0]};
            2'd2:    rd_extract_c = {24'h0, ram_rdata[{acc_lane_q, 3'b000} +: 8]};
            default: rd_extract_c = ram_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (in_req_mem_access) begin
                    state_d = req_fault_c ? StRespond : StAccess;
                end
            end
            StAccess: begin
                state_d = StWait;
                cnt_d   = CNT_W'(WAIT_STATES);
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StRespond;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs and latched access attributes
    always_comb begin
        acc_write_d      = acc_write_q;
        acc_size_d       = acc_size_q;
        acc_lane_d       = acc_lane_q;
        ram_addr_d       = ram_addr;
        ram_wdata_d      = ram_wdata;
        out_data_d       = out_data;
        ram_re_d         = accept_c && !in_access_type;
        ram_we_d         = accept_c && in_access_type;
        ram_byte_en_d    = accept_c ? lanes_c : 4'b0000;
        out_data_ready_d = (state_d == StRespond);
        out_fault_d      = reject_c;
        out_busy_d       = (state_d != StIdle);
        if (accept_c) begin
            acc_write_d = in_access_type;
            acc_size_d  = in_access_size;
            acc_lane_d  = in_addr[1:0];
            ram_addr_d  = in_addr[BYTE_ADDR_W-1:2];
            ram_wdata_d = in_access_type ? wdata_c : 32'd0;
        end
        if (reject_c) begin
            out_data_d = 32'd0;
        end else if ((state_q == StWait) && (cnt_q == '0)) begin
            out_data_d = acc_write_q ? 32'd0 : rd_extract_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_write_q    <= 1'b0;
            acc_size_q     <= 2'd0;
            acc_lane_q     <= 2'd0;
            out_data       <= 32'd0;
            out_data_ready <= 1'b0;
            out_fault      <= 1'b0;
            out_busy       <= 1'b0;
            ram_addr       <= '0;
            ram_wdata      <= 32'd0;
            ram_byte_en    <= 4'b0000;
            ram_we         <= 1'b0;
            ram_re         <= 1'b0;
        end else begin
            acc_write_q    <= acc_write_d;
            acc_size_q     <= acc_size_d;
            acc_lane_q     <= acc_lane_d;
            out_data       <= out_data_d;
            out_data_ready <= out_data_ready_d;
            out_fault      <= out_fault_d;
            out_busy       <= out_busy_d;
            ram_addr       <= ram_addr_d;
            ram_wdata      <= ram_wdata_d;
            ram_byte_en    <= ram_byte_en_d;
            ram_we         <= ram_we_d;
            ram_re         <= ram_re_d;
        end
    end

endmodule
